// File: rtl/adder_sched_pkg.sv
// adder_sched_pkg: shared limb width, FSM encoding and width helpers for adder_rr_sched
package adder_sched_pkg;
  localparam int LIMB_W = 16;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  function automatic int opw_of(input int nlimb);
    return LIMB_W * nlimb;
  endfunction
  function automatic int idw_of(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/RCA16b.sv
// RCA16b: 16-bit ripple-carry adder, ports COUT/CIN/SOUT/A/B
module RCA16b
  import adder_sched_pkg::*;
(
  output logic              COUT,
  input  logic              CIN,
  output logic [LIMB_W-1:0] SOUT,
  input  logic [LIMB_W-1:0] A,
  input  logic [LIMB_W-1:0] B
);
  logic [LIMB_W:0] c;
  assign c[0] = CIN;
  genvar i;
  for (i = 0; i < LIMB_W; i++) begin : g_fa
    assign SOUT[i] = A[i] ^ B[i] ^ c[i];
    assign c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
  end
  assign COUT = c[LIMB_W];
endmodule

// File: rtl/adder_rr_sched.sv
// adder_rr_sched: round-robin sharing of one RCA16b for multi-limb adds, returns {carry, sum} tagged with requester id
module adder_rr_sched
  import adder_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int NLIMB = 2,
  localparam int OPW = opw_of(NLIMB),
  localparam int IDW = idw_of(NREQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*OPW-1:0] req_a,
  input  logic [NREQ*OPW-1:0] req_b,
  input  logic [NREQ-1:0]     req_cin,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [OPW:0]        rsp_sum
);
  localparam int LW = idw_of(NLIMB);
  logic [1:0] state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] gnt_idx;
  logic gnt_any;
  logic [OPW-1:0] a_q;
  logic [OPW-1:0] b_q;
  logic carry;
  logic [LW-1:0] limb;
  logic [LIMB_W-1:0] sout;
  logic cout;
  logic last;
  function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] v, input logic [IDW-1:0] p);
    logic [IDW:0] r;
    r = '0;
    for (int k = NREQ; k >= 1; k--)
      if (v[(int'(p) + k) % NREQ]) r = {1'b1, IDW'((int'(p) + k) % NREQ)};
    return r;
  endfunction
  assign {gnt_any, gnt_idx} = rr_pick(req_valid, ptr);
  assign req_ready = (state == IDLE && gnt_any) ? NREQ'(1) << gnt_idx : '0;
  assign rsp_valid = state == DONE;
  assign last = limb == LW'(NLIMB - 1);
  RCA16b u_rca (
    .COUT(cout),
    .CIN (carry),
    .SOUT(sout),
    .A   (a_q[limb*LIMB_W +: LIMB_W]),
    .B   (b_q[limb*LIMB_W +: LIMB_W])
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr <= IDW'(NREQ - 1);
      a_q <= '0;
      b_q <= '0;
      carry <= 1'b0;
      limb <= '0;
      rsp_id <= '0;
      rsp_sum <= '0;
    end else if (state == IDLE) begin
      if (gnt_any) begin
        a_q <= req_a[gnt_idx*OPW +: OPW];
        b_q <= req_b[gnt_idx*OPW +: OPW];
        carry <= req_cin[gnt_idx];
        rsp_id <= gnt_idx;
        ptr <= gnt_idx;
        limb <= '0;
        state <= RUN;
      end
    end else if (state == RUN) begin
      rsp_sum[limb*LIMB_W +: LIMB_W] <= sout;
      carry <= cout;
      if (last) begin
        rsp_sum[OPW] <= cout;
        state <= DONE;
      end else begin
        limb <= limb + LW'(1);
      end
    end else if (rsp_ready || state != DONE) begin
      state <= IDLE;
    end
  end
endmodule
